// File: rtl/packet_tx_framer_if.sv
// Request and byte-stream handshake bundle for the TX packet framer.
// master: upstream responders plus the UART side; slave: the framer itself.
interface packet_tx_framer_if #(
  parameter int MAX_PAYLOAD = 16
);
  logic                     req_valid;
  logic                     req_ready;
  logic [7:0]               req_opcode;
  logic [7:0]               req_len;
  logic [8*MAX_PAYLOAD-1:0] req_payload;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready;

  modport master (
    output req_valid, req_opcode, req_len, req_payload, tx_ready,
    input  req_ready, tx_data, tx_valid
  );

  modport slave (
    input  req_valid, req_opcode, req_len, req_payload, tx_ready,
    output req_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/packet_tx_framer.sv
// Device-to-PC packet framer: SYNC, LEN, OPCODE, payload, CRC-8 streamed
// one byte per accepted handshake towards the UART transmitter.
module packet_tx_framer #(
  parameter int         MAX_PAYLOAD = 16,
  parameter logic [7:0] SYNC        = 8'hAA
) (
  input  logic                CLK,
  input  logic                rst,
  packet_tx_framer_if.slave   bus_if,
  output logic                busy,
  output logic                done,
  output logic                err_len
);

  typedef enum logic [2:0] {IDLE, S_SYNC, S_LEN, S_OP, S_PAY, S_CRC} state_t;

  state_t                   state_q, state_d;
  logic [7:0]               op_q, op_d;
  logic [7:0]               len_q, len_d;
  logic [7:0]               idx_q, idx_d;
  logic [7:0]               crc_q, crc_d;
  logic [7:0]               data_q, data_d;
  logic [8*MAX_PAYLOAD-1:0] pay_q, pay_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     fire;

  // CRC-8, poly 0x07, MSB-first, one byte folded into the running value.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Byte mux over the latched payload; out-of-range indices read as zero.
  function automatic logic [7:0] pay_byte(input logic [8*MAX_PAYLOAD-1:0] p,
                                          input logic [7:0] i);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < MAX_PAYLOAD; k++) begin
      if (i == 8'(k)) b = p[8*k +: 8];
    end
    return b;
  endfunction

  assign bus_if.req_ready = (state_q == IDLE);
  assign bus_if.tx_valid  = (state_q != IDLE);
  assign bus_if.tx_data   = data_q;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign err_len          = err_q;

  // Next-state, next byte and CRC accumulation; tx_data is computed one
  // step ahead so the output register holds it stable through stalls.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    idx_d   = idx_q;
    crc_d   = crc_q;
    data_d  = data_q;
    pay_d   = pay_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    fire    = (state_q != IDLE) && bus_if.tx_ready;
    case (state_q)
      IDLE: begin
        if (bus_if.req_valid) begin
          if (bus_if.req_len > 8'(MAX_PAYLOAD)) begin
            err_d = 1'b1;
          end else begin
            op_d    = bus_if.req_opcode;
            len_d   = bus_if.req_len;
            pay_d   = bus_if.req_payload;
            idx_d   = 8'd0;
            crc_d   = 8'h00;
            data_d  = SYNC;
            state_d = S_SYNC;
          end
        end
      end
      S_SYNC: begin
        if (fire) begin
          data_d  = len_q + 8'd1;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (fire) begin
          crc_d   = crc8_step(crc_q, len_q + 8'd1);
          data_d  = op_q;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (fire) begin
          crc_d = crc8_step(crc_q, op_q);
          if (len_q == 8'd0) begin
            data_d  = crc_d;
            state_d = S_CRC;
          end else begin
            idx_d   = 8'd0;
            data_d  = pay_byte(pay_q, 8'd0);
            state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (fire) begin
          crc_d = crc8_step(crc_q, pay_byte(pay_q, idx_q));
          if (idx_q == len_q - 8'd1) begin
            data_d  = crc_d;
            state_d = S_CRC;
          end else begin
            idx_d  = idx_q + 8'd1;
            data_d = pay_byte(pay_q, idx_q + 8'd1);
          end
        end
      end
      S_CRC: begin
        if (fire) begin
          done_d  = 1'b1;
          data_d  = 8'h00;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any packet in flight.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 8'd0;
      crc_q   <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      crc_q   <= crc_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
    op_q  <= op_d;
    len_q <= len_d;
    pay_q <= pay_d;
  end

endmodule
